// File: rtl/exec_unit_scheduler.sv
// Purpose: sequences MDU/FPU ops (start pulse, stall until done, writeback strobe); SCHED_PERF_CNT_EN adds perf counters.
// Latency: start and stall in the issue cycle; wb_valid one cycle after the unit's done pulse.
// Backpressure: stall held through the whole wait; aborted by flush or after TIMEOUT_CYCLES wait cycles.
module exec_unit_scheduler #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       mul_en,
    input  logic       fpu_en,
    input  logic [4:0] rd_in,
    input  logic       flush,
    input  logic       mdu_done,
    input  logic       fpu_done,
    output logic       mdu_start,
    output logic       fpu_start,
    output logic       stall,
    output logic       wb_valid,
    output logic [1:0] wb_sel,
    output logic [4:0] wb_rd,
    output logic       timeout_err,
    output logic       conflict_err
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] unit_ops,
    output logic [15:0] timeouts
`endif
);
    typedef enum logic [1:0] {IDLE, MDU_WAIT, FPU_WAIT, WB} state_t;

    localparam logic [1:0]       SEL_MDU  = 2'b01;
    localparam logic [1:0]       SEL_FPU  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       rd_q;
    logic [4:0]       wb_rd_q;
    logic [1:0]       unit_q;
    logic             unit_done;

    always_comb begin
        state_nxt    = state;
        mdu_start    = 1'b0;
        fpu_start    = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        wb_sel       = 2'b00;
        timeout_err  = 1'b0;
        conflict_err = 1'b0;
        unit_done    = (state == MDU_WAIT) ? mdu_done : fpu_done;
        case (state)
            IDLE: begin
                if (issue_valid && !flush) begin
                    if (fpu_en) begin
                        fpu_start    = 1'b1;
                        stall        = 1'b1;
                        conflict_err = mul_en;
                        state_nxt    = FPU_WAIT;
                    end else if (mul_en) begin
                        mdu_start = 1'b1;
                        stall     = 1'b1;
                        state_nxt = MDU_WAIT;
                    end
                end
            end
            MDU_WAIT, FPU_WAIT: begin
                stall = 1'b1;
                // flush beats done, done beats timeout
                if (flush) begin
                    state_nxt = IDLE;
                end else if (unit_done) begin
                    state_nxt = WB;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WB: begin
                wb_valid  = 1'b1;
                wb_sel    = unit_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // outputs are quiet while reset is held, whatever the inputs say
        if (rst) begin
            state_nxt    = IDLE;
            mdu_start    = 1'b0;
            fpu_start    = 1'b0;
            stall        = 1'b0;
            wb_valid     = 1'b0;
            wb_sel       = 2'b00;
            timeout_err  = 1'b0;
            conflict_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rd_q     <= '0;
            unit_q   <= 2'b00;
            wb_rd_q  <= '0;
        end else begin
            state <= state_nxt;
            if (mdu_start || fpu_start) begin
                rd_q     <= rd_in;
                unit_q   <= fpu_start ? SEL_FPU : SEL_MDU;
                wait_cnt <= '0;
            end else if (state == MDU_WAIT || state == FPU_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state_nxt == WB) begin
                wb_rd_q <= rd_q;
            end
        end
    end

    assign wb_rd = rst ? 5'd0 : wb_rd_q;

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            unit_ops     <= '0;
            timeouts     <= '0;
        end else begin
            if (stall)       stall_cycles <= stall_cycles + 32'd1;
            if (wb_valid)    unit_ops     <= unit_ops + 32'd1;
            if (timeout_err) timeouts     <= timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_unit_scheduler.sv
// Random + directed scheduler bench: operation-level model feeds event and stall-run scoreboards.
module tb_exec_unit_scheduler;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst, issue_valid, mul_en, fpu_en, flush, mdu_done, fpu_done;
    logic [4:0] rd_in;
    logic       mdu_start, fpu_start, stall, wb_valid, timeout_err, conflict_err;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cycles, unit_ops;
    logic [15:0] timeouts;
`endif

    always #5 clk = ~clk;

    exec_unit_scheduler #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .mul_en(mul_en), .fpu_en(fpu_en),
        .rd_in(rd_in), .flush(flush), .mdu_done(mdu_done), .fpu_done(fpu_done),
        .mdu_start(mdu_start), .fpu_start(fpu_start), .stall(stall), .wb_valid(wb_valid),
        .wb_sel(wb_sel), .wb_rd(wb_rd), .timeout_err(timeout_err), .conflict_err(conflict_err)
`ifdef SCHED_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .unit_ops(unit_ops), .timeouts(timeouts)
`endif
    );

    typedef struct {
        int         cyc;
        logic [11:0] vec;
    } ev_t;

    ev_t         evq[$];
    int          runq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          run_len = 0;
    logic [4:0]  exp_wb_rd;
    logic [31:0] m_stall, m_ops;
    logic [15:0] m_tos;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ev_vec(input bit ms, input bit fs, input bit wv, input bit to,
                                           input bit ce, input logic [1:0] sel, input logic [4:0] rd);
        return {ms, fs, wv, to, ce, sel, rd};
    endfunction

    task automatic push_ev(input int c, input logic [11:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        evq.push_back(e);
    endtask

    task automatic push_run(input int n);
        runq.push_back(n);
        m_stall += 32'(n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        issue_valid = 1'b0; mul_en = 1'b0; fpu_en = 1'b0;
        flush = 1'b0; mdu_done = 1'b0; fpu_done = 1'b0;
    endtask

    task automatic set_done(input bit uf, input bit v);
        if (uf) fpu_done = v; else mdu_done = v;
    endtask

    // garbage on the decode side plus stray done pulses from the other unit
    task automatic wait_noise(input bit uf);
        issue_valid = 1'($urandom); mul_en = 1'($urandom); fpu_en = 1'($urandom);
        rd_in = 5'($urandom); flush = 1'b0;
        if (uf) begin fpu_done = 1'b0; mdu_done = 1'($urandom); end
        else begin mdu_done = 1'b0; fpu_done = 1'($urandom); end
    endtask

    // outcome: 0 = done at wait cycle k, 1 = timeout, 2 = flush at wait cycle k
    task automatic run_op(input bit uf, input bit conf, input logic [4:0] rd,
                          input int outcome, input int k, input bit x);
        int c0;
        issue_valid = 1'b1; fpu_en = uf; mul_en = conf | !uf; rd_in = rd; flush = 1'b0;
        mdu_done = 1'($urandom); fpu_done = 1'($urandom);
        c0 = cyc;
        push_ev(c0, ev_vec(!uf, uf, 1'b0, 1'b0, conf, 2'b00, 5'd0));
        for (int i = 1; i <= T; i++) begin
            step();
            wait_noise(uf);
            if (i == k && outcome == 0) begin
                set_done(uf, 1'b1);
                push_ev(c0 + k + 1, ev_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, uf ? 2'b10 : 2'b01, rd));
                push_run(k + 1);
                m_ops += 32'd1;
                step();
                exp_wb_rd = rd;
                issue_valid = 1'($urandom); mul_en = 1'($urandom); fpu_en = 1'($urandom);
                rd_in = 5'($urandom); mdu_done = 1'b0; fpu_done = 1'b0;
                step();
                return;
            end
            if ((i == k && outcome == 2) || (i == T && outcome == 1)) begin
                if (outcome == 2) begin
                    flush = 1'b1;
                    set_done(uf, x);
                end else begin
                    push_ev(c0 + T, ev_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0));
                    m_tos += 16'd1;
                end
                push_run(i + 1);
                step();
                quiet();
                set_done(uf, x);
                step();
                return;
            end
        end
    endtask

    task automatic idle_cycle();
        int v = $urandom_range(0, 2);
        quiet();
        mdu_done = 1'($urandom); fpu_done = 1'($urandom); rd_in = 5'($urandom);
        case (v)
            0: begin mul_en = 1'($urandom); fpu_en = 1'($urandom); end
            1: issue_valid = 1'b1;
            default: begin issue_valid = 1'b1; mul_en = 1'b1; fpu_en = 1'($urandom); flush = 1'b1; end
        endcase
        step();
    endtask

    task automatic run_random();
        bit conf = ($urandom_range(0, 3) == 0);
        bit uf   = conf ? 1'b1 : 1'($urandom);
        run_op(uf, conf, 5'($urandom), $urandom_range(0, 2), $urandom_range(1, T), 1'($urandom));
    endtask

    task automatic reset_mid();
        int c0;
        issue_valid = 1'b1; fpu_en = 1'b1; mul_en = 1'b0; rd_in = 5'($urandom); flush = 1'b0;
        mdu_done = 1'b0; fpu_done = 1'b0;
        c0 = cyc;
        push_ev(c0, ev_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0));
        step(); wait_noise(1'b1);
        step(); wait_noise(1'b1);
        step();
        quiet(); issue_valid = 1'b1; mul_en = 1'b1; fpu_done = 1'b1;
        rst = 1'b1;
        exp_wb_rd = 5'd0;
        push_run(3);
        step();
        rst = 1'b0;
        quiet();
        m_stall = '0; m_ops = '0; m_tos = '0;
`ifdef SCHED_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0 || unit_ops !== 32'd0 || timeouts !== 16'd0) begin
            errors++;
            $display("FAIL perf_after_reset: got %0d/%0d/%0d want 0/0/0", stall_cycles, unit_ops, timeouts);
        end
`endif
    endtask

    always @(negedge clk) begin
        logic [11:0] act;
        ev_t e;
        act = {mdu_start, fpu_start, wb_valid, timeout_err, conflict_err, wb_sel,
               wb_valid ? wb_rd : 5'd0};
        if (rst) begin
            checks++;
            if ({act, stall, wb_rd} !== 18'd0) begin
                errors++;
                $display("FAIL reset_outputs @%0d: got %b stall %b rd %0d want all 0", cyc, act, stall, wb_rd);
            end
        end
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_event: want %b at cycle %0d, not seen", evq[0].vec, evq[0].cyc);
            evq.delete(0);
        end
        if (act !== 12'd0) begin
            checks++;
            if (evq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event @%0d: got %b want none", cyc, act);
            end else begin
                e = evq.pop_front();
                if (e.cyc != cyc || e.vec !== act) begin
                    errors++;
                    $display("FAIL event: got %b at cycle %0d want %b at cycle %0d", act, cyc, e.vec, e.cyc);
                end
            end
        end
        checks++;
        if (wb_rd !== exp_wb_rd) begin
            errors++;
            $display("FAIL wb_rd @%0d: got %0d want %0d", cyc, wb_rd, exp_wb_rd);
        end
        if (stall === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            checks++;
            if (runq.size() == 0) begin
                errors++;
                $display("FAIL stall_run @%0d: got %0d cycles want none", cyc, run_len);
            end else if (runq.pop_front() != run_len) begin
                errors++;
                $display("FAIL stall_run @%0d: got %0d cycles, differs from expected", cyc, run_len);
            end
            run_len = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        quiet();
        rd_in = 5'd0;
        exp_wb_rd = 5'd0;
        m_stall = '0; m_ops = '0; m_tos = '0;
        repeat (3) begin
            step();
            issue_valid = 1'b1; mul_en = 1'($urandom); fpu_en = 1'($urandom); rd_in = 5'($urandom);
        end
        step();
        rst = 1'b0;
        quiet();
        run_op(1'b0, 1'b0, 5'd7, 0, 3, 1'b0);   // MDU, done three cycles after issue
        run_op(1'b1, 1'b1, 5'd5, 0, 2, 1'b0);   // both enables: FPU wins with conflict
        run_op(1'b1, 1'b0, 5'd9, 1, 1, 1'b1);   // timeout then late done
        run_op(1'b0, 1'b0, 5'd12, 2, 2, 1'b1);  // flush with done, late done in IDLE
        run_op(1'b0, 1'b0, 5'd3, 0, 1, 1'b0);   // back-to-back, minimum latency
        run_op(1'b1, 1'b0, 5'd4, 0, 1, 1'b0);
        run_op(1'b0, 1'b0, 5'd6, 0, T, 1'b0);   // done on the timeout cycle
        run_op(1'b1, 1'b0, 5'd8, 2, T, 1'b0);   // flush on the timeout cycle
        reset_mid();
        repeat (200) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            run_random();
        end
        quiet();
        repeat (4) step();
        checks++;
        if (evq.size() != 0 || runq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d events %0d stall runs pending want 0", evq.size(), runq.size());
        end
`ifdef SCHED_PERF_CNT_EN
        checks++;
        if (stall_cycles !== m_stall || unit_ops !== m_ops || timeouts !== m_tos) begin
            errors++;
            $display("FAIL perf_final: got %0d/%0d/%0d want %0d/%0d/%0d",
                     stall_cycles, unit_ops, timeouts, m_stall, m_ops, m_tos);
        end
`endif
        $display("Model totals since last reset: %0d stall cycles, %0d unit ops, %0d timeouts", m_stall, m_ops, m_tos);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_unit_scheduler.md
Name: exec_unit_scheduler

Overview:
- Sequences the multi-cycle execution resources (MDU, FPU) of the RV32IMF core, driven by the decoder's mul_en/fpu_en strobes.
- Sits between decode and execute: it issues a one-cycle start pulse to the selected unit, stalls the pipeline until that unit reports done, then signals writeback.
- Single-cycle ALU instructions pass through without stalling.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the operation is aborted (legal range 2..255).
- CNT_W, 8, width of the internal wait counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  a decoded instruction is present in execute.
- mul_en  input  1  decoder strobe: instruction targets the MDU.
- fpu_en  input  1  decoder strobe: instruction targets the FPU.
- rd_in  input  5  destination register of the issuing instruction.
- flush  input  1  pipeline flush (branch or jump redirect).
- mdu_done  input  1  MDU result valid (one-cycle pulse).
- fpu_done  input  1  FPU result valid (one-cycle pulse).
- mdu_start  output  1  one-cycle MDU launch pulse.
- fpu_start  output  1  one-cycle FPU launch pulse.
- stall  output  1  hold PC, IF/ID and ID/EX registers.
- wb_valid  output  1  one-cycle writeback strobe for the completed unit result.
- wb_sel  output  2  result source: 01 = MDU, 10 = FPU, 00 = none.
- wb_rd  output  5  latched destination register.
- timeout_err  output  1  one-cycle pulse when an operation is aborted on timeout.
- conflict_err  output  1  one-cycle pulse when mul_en and fpu_en are issued together.

Behaviour:
- States: IDLE, MDU_WAIT, FPU_WAIT, WB.
- Reset: state=IDLE, wait counter=0, wb_rd=0, latched unit=none. Every output is 0 during and after reset.
- IDLE, with issue_valid and mul_en and not fpu_en:
  - mdu_start=1 in the same cycle (combinational); stall=1 in the same cycle.
  - Latch rd_in and unit=MDU; move to MDU_WAIT; clear the counter.
- IDLE, with issue_valid and fpu_en: same sequence using fpu_start and FPU_WAIT.
- IDLE, with issue_valid and both enables set: FPU takes priority; conflict_err=1 for that cycle.
- IDLE, with issue_valid and neither enable set: no action, stall=0.
- IDLE, with issue_valid=0: enables are ignored.
- IDLE, with flush=1: no issue takes place, even if issue_valid=1.
- MDU_WAIT / FPU_WAIT:
  - stall=1; the counter increments every cycle.
  - The matching done signal moves the block to WB.
  - The non-matching done signal is ignored.
- Wait-state timeout: if the counter equals TIMEOUT_CYCLES-1 and done is not asserted, then timeout_err=1 and the block returns to IDLE. No wb_valid is produced; stall drops in the next cycle.
- Wait-state done on the timeout cycle: done wins (the block goes to WB, no timeout_err).
- Wait-state flush: the block returns to IDLE with no wb_valid. Flush wins over a simultaneous done or timeout. Any later done from the aborted unit is ignored in IDLE.
- WB:
  - wb_valid=1, wb_sel=latched unit, wb_rd=latched rd, stall=0.
  - issue_valid is ignored (it still refers to the completing instruction); next state is IDLE.
- Outside WB: wb_sel=00. wb_rd holds its last value.
- Latency: done at cycle N gives wb_valid at N+1. The minimum issue-to-writeback time is 2 cycles (done arriving in the first WAIT cycle).
- Back-to-back unit instructions: the next one is issued in the IDLE cycle after WB. There is no bubble beyond WB.
- Start pulses are never asserted outside IDLE. At most one start pulse is asserted per cycle.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- When defined, adds outputs:
  - stall_cycles (32-bit): increments on every cycle with stall=1.
  - unit_ops (32-bit): increments on every wb_valid.
  - timeouts (16-bit): increments on every timeout_err.
- All three counters are cleared by rst, wrap modulo 2^width and are never saturated.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- MDU op: issue_valid=1, mul_en=1, rd_in=7; mdu_done 3 cycles later.
  - Required: mdu_start pulses once; stall high for 4 cycles.
  - Required: next cycle wb_valid=1, wb_sel=01, wb_rd=7, stall=0.
- FPU op with conflict: issue_valid=1, mul_en=1 and fpu_en=1.
  - Required: fpu_start=1, mdu_start=0, conflict_err pulse; FPU_WAIT entered.
- Timeout: TIMEOUT_CYCLES=4, FPU issued, fpu_done never asserted.
  - Required: timeout_err in the 4th WAIT cycle, no wb_valid, stall=0 in the following cycle.
- Flush during MDU_WAIT together with mdu_done.
  - Required: IDLE next cycle, no wb_valid; a late mdu_done in IDLE has no effect.
- Back-to-back: MDU op immediately followed by an FPU op.
  - Required: fpu_start occurs in the cycle after the MDU wb_valid; exactly one writeback per op.
- Reset mid-operation: rst asserted in FPU_WAIT.
  - Required: all outputs 0 next cycle, state IDLE; with SCHED_PERF_CNT_EN, all counters read 0.
